// File: rtl/relu_maxpool_2x2_if.sv
// Stream interface between the conv adder tree / controller and the ReLU + 2x2 max-pool stage.
interface relu_maxpool_2x2_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             frame_done;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output frame_done
  );
endinterface

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 signed max pooling over a raster-ordered conv output map.
// Optional feature macro: POOL_RELU_EN (defined = ReLU applied, undefined = ReLU bypassed).
module relu_maxpool_2x2 #(
  parameter int WIDTH   = 16,
  parameter int IMG_W   = 24,
  parameter int IMG_H   = 24,
  parameter int VLD_DLY = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  relu_maxpool_2x2_if.slave   bus
);

  localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int HALF_W = IMG_W / 2;
  localparam int LB_AW  = (HALF_W > 2) ? $clog2(HALF_W) : 1;

  function automatic logic signed [WIDTH-1:0] smax(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [VLD_DLY-1:0]        vld_dly_r;
  logic [VLD_DLY:0]          vld_chain_s;
  logic                      s_valid_s;
  logic [COL_W-1:0]          col_r;
  logic [ROW_W-1:0]          row_r;
  logic signed [WIDTH-1:0]   pair_r;
  logic signed [WIDTH-1:0]   line_buf_r [HALF_W];
  logic                      out_valid_r;
  logic [WIDTH-1:0]          out_data_r;
  logic                      frame_done_r;

  logic signed [WIDTH-1:0]   x_s;
  logic signed [WIDTH-1:0]   r_s;
  logic signed [WIDTH-1:0]   p_s;
  logic signed [WIDTH-1:0]   pool_s;
  logic [LB_AW-1:0]          lb_idx_s;
  logic                      last_col_s;
  logic                      last_row_s;

  assign vld_chain_s = {vld_dly_r, bus.in_valid};
  assign s_valid_s   = vld_dly_r[VLD_DLY-1];

  // ReLU, horizontal and vertical maxima for the current sample
  always_comb begin
    x_s = $signed(bus.in_data);
`ifdef POOL_RELU_EN
    if (x_s < $signed({WIDTH{1'b0}})) begin
      r_s = '0;
    end else begin
      r_s = x_s;
    end
`else
    r_s = x_s;
`endif
    p_s        = smax(pair_r, r_s);
    lb_idx_s   = LB_AW'(col_r >> 1);
    pool_s     = smax(line_buf_r[lb_idx_s], p_s);
    last_col_s = (col_r == COL_W'(IMG_W - 1));
    last_row_s = (row_r == ROW_W'(IMG_H - 1));
  end

  // Valid delay line, raster counters, pair register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_dly_r    <= '0;
      col_r        <= '0;
      row_r        <= '0;
      pair_r       <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      frame_done_r <= 1'b0;
    end else begin
      vld_dly_r <= vld_chain_s[VLD_DLY-1:0];
      if (s_valid_s) begin
        if (last_col_s) begin
          col_r <= '0;
          row_r <= last_row_s ? '0 : row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
        if (!col_r[0]) begin
          pair_r <= r_s;
        end
        // Odd row, odd col closes a 2x2 block
        out_valid_r  <= row_r[0] & col_r[0];
        frame_done_r <= last_row_s & last_col_s;
        if (row_r[0] && col_r[0]) begin
          out_data_r <= pool_s;
        end
      end else begin
        out_valid_r  <= 1'b0;
        frame_done_r <= 1'b0;
      end
    end
  end

  // Line buffer holds the top-row horizontal maxima; contents need no reset
  always_ff @(posedge clk) begin
    if (s_valid_s && !row_r[0] && col_r[0]) begin
      line_buf_r[lb_idx_s] <= p_s;
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Scoreboard bench for relu_maxpool_2x2 on a 4x4 map with randomized gaps and frames.
module tb_relu_maxpool_2x2;

  localparam int W = 16;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NPIX = IW * IH;

  typedef struct {
    logic [W-1:0] d;
    logic         fd;
    int           due;
  } exp_t;

  logic clk;
  logic rst_n;
  logic stim_valid;
  logic [W-1:0] stim_data;
  logic [W-1:0] dq [5];
  exp_t q [$];
  int cyc;
  int checks;
  int errors;
  logic [W-1:0] last_exp;

  relu_maxpool_2x2_if #(.WIDTH(W)) bus ();

  relu_maxpool_2x2 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .VLD_DLY(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder-tree latency model: data appears five cycles after its valid
  always @(posedge clk) begin
    dq[0] <= stim_valid ? stim_data : 16'hDEAD;
    for (int k = 1; k < 5; k++) dq[k] <= dq[k-1];
  end

  assign bus.in_valid = stim_valid;
  assign bus.in_data  = dq[4];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic feed_frame(input logic [W-1:0] px [NPIX], input int max_gap);
    int pooled [4];
    int m;
    int v;
    for (int by = 0; by < 2; by++) begin
      for (int bx = 0; bx < 2; bx++) begin
        m = -100000;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            v = relu(int'($signed(px[(2*by+dy)*IW + 2*bx + dx])));
            if (v > m) m = v;
          end
        end
        pooled[by*2+bx] = m;
      end
    end
    for (int i = 0; i < NPIX; i++) begin
      int r;
      int c;
      @(negedge clk);
      stim_valid = 1'b1;
      stim_data  = px[i];
      r = i / IW;
      c = i % IW;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        q.push_back('{d: W'(pooled[(r/2)*2 + c/2]), fd: (i == NPIX-1), due: cyc + 6});
      end
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        stim_valid = 1'b0;
        stim_data  = 16'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stim_valid = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on each strobe, checks hold and reset state otherwise
  initial begin
    logic rs;
    cyc = 0;
    forever begin
      @(posedge clk);
      rs = rst_n;
      cyc++;
      #1;
      if (!rs) begin
        last_exp = '0;
        chk("reset_out_valid", W'(bus.out_valid), 16'h0000);
        chk("reset_out_data", bus.out_data, 16'h0000);
        chk("reset_frame_done", W'(bus.frame_done), 16'h0000);
      end else if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got data %h with empty scoreboard (cycle %0d)", bus.out_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("frame_done", W'(bus.frame_done), W'(e.fd));
          chk("latency_cycle", W'(cyc), W'(e.due));
          last_exp = e.d;
        end
      end else begin
        chk("hold_out_data", bus.out_data, last_exp);
        chk("idle_frame_done", W'(bus.frame_done), 16'h0000);
      end
    end
  end

  initial begin
    logic [W-1:0] inc [NPIX];
    logic [W-1:0] dec [NPIX];
    logic [W-1:0] neg [NPIX];
    logic [W-1:0] sgn [NPIX];
    logic [W-1:0] rnd [NPIX];
    int wait_cyc;
    checks = 0;
    errors = 0;
    last_exp = '0;
    for (int i = 0; i < NPIX; i++) begin
      inc[i] = W'(i + 1);
      dec[i] = W'(NPIX - i);
      neg[i] = 16'hFFFD;
      sgn[i] = 16'($urandom_range(0, 16'h0FFF));
    end
    sgn[0] = 16'h8000;
    sgn[1] = 16'h7FFF;
    sgn[4] = 16'h8001;
    sgn[5] = 16'h0000;

    rst_n = 1'b0;
    stim_valid = 1'b0;
    stim_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    feed_frame(inc, 0);
    feed_frame(neg, 0);
    feed_frame(inc, 3);
    idle(10);

    // Abort a frame after six samples; the sixth is still in the delay line
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stim_valid = 1'b1;
      stim_data  = inc[i];
    end
    @(negedge clk);
    stim_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    feed_frame(inc, 0);
    idle(10);

    feed_frame(inc, 0);
    feed_frame(dec, 0);
    feed_frame(sgn, 1);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) rnd[i] = 16'($urandom);
      feed_frame(rnd, 2);
    end
    idle(1);

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending outputs expected 0", q.size());
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
